mouse_pos_ctrl: RTL and testbench

- Converts the 3-byte PS/2 mouse packet stream into the on-screen cursor position PosH/PosV.
- Those positions feed the cursor decoder that draws the 12x12 arrow against the VGA counters ContH/ContV.
- Movement is accumulated between frames and applied once per frame, in vertical blanking, so the cursor never tears mid-frame.
- Sits between the PS/2 byte receiver and the cursor decoder.

---
 rtl/mouse_pos_ctrl_if.sv | 37 +++
 rtl/mouse_pos_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mouse_pos_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mouse_pos_ctrl_if.sv
// mouse_pos_ctrl_if
// Groups the byte stream from the PS/2 receiver, the VGA scan counters and the
// cursor/button results into one bundle.
//   master : environment side (PS/2 receiver + VGA timing); drives rx_*/Cont*,
//            observes the cursor outputs.
//   slave  : mouse_pos_ctrl; consumes rx_*/Cont*, drives Pos*/Btn*/upd/pkt_err.
// Signals:
//   rx_data[7:0]  byte from the PS/2 receiver, valid while rx_done=1
//   rx_done       one-cycle strobe, byte available
//   ContH/ContV   VGA horizontal/vertical counters
//   PosH/PosV     cursor position (top-left corner of the 12x12 arrow)
//   BtnL/R/M      mouse buttons
//   upd           one-cycle pulse after PosH/PosV were rewritten
//   pkt_err       one-cycle pulse on sync error or inter-byte timeout
interface mouse_pos_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_done;
    logic [9:0] ContH;
    logic [9:0] ContV;
    logic [9:0] PosH;
    logic [9:0] PosV;
    logic       BtnL;
    logic       BtnR;
    logic       BtnM;
    logic       upd;
    logic       pkt_err;

    modport master (
        output rx_data, rx_done, ContH, ContV,
        input  PosH, PosV, BtnL, BtnR, BtnM, upd, pkt_err
    );

    modport slave (
        input  rx_data, rx_done, ContH, ContV,
        output PosH, PosV, BtnL, BtnR, BtnM, upd, pkt_err
    );
endinterface

// File: rtl/mouse_pos_ctrl.sv
// mouse_pos_ctrl
// Assembles 3-byte PS/2 mouse packets, accumulates the X/Y movement between
// frames and applies it to the cursor position once per frame, on the first
// vertical-blanking line, so the cursor never tears mid-frame.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    mouse_pos_ctrl_if.slave (rx_data/rx_done, ContH/ContV in;
//          PosH/PosV, BtnL/BtnR/BtnM, upd, pkt_err out, all registered)
module mouse_pos_ctrl #(
    parameter int unsigned H_MAX   = 628,
    parameter int unsigned V_MAX   = 468,
    parameter int unsigned H_INIT  = 320,
    parameter int unsigned V_INIT  = 240,
    parameter int unsigned V_APPLY = 480,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             reset,
    mouse_pos_ctrl_if.slave  bus
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StGot0, StGot1} state_t;

    state_t            r_state;
    logic [TW-1:0]     r_tmo;
    logic [2:0]        r_hdr_btn;   // {M, R, L} from byte0
    logic              r_x_sign;
    logic              r_y_sign;
    logic              r_x_ovf;
    logic              r_y_ovf;
    logic [7:0]        r_dx;
    logic signed [11:0] r_acc_x;
    logic signed [11:0] r_acc_y;
    logic [9:0]        r_pos_h;
    logic [9:0]        r_pos_v;
    logic              r_btn_l;
    logic              r_btn_r;
    logic              r_btn_m;
    logic              r_upd;
    logic              r_pkt_err;
    logic              r_cond;

    logic              w_pkt_done;
    logic              w_cond;
    logic              w_tick;
    logic signed [8:0] w_dx;
    logic signed [8:0] w_dy;
    logic signed [12:0] w_sum_h;
    logic signed [12:0] w_sum_v;

    // Overflow replaces the magnitude with the largest value of the given sign.
    function automatic logic signed [8:0] form_delta(input logic sign, input logic ovf,
                                                     input logic [7:0] mag);
        if (ovf) begin
            return sign ? 9'sh100 : 9'sh0FF;
        end
        return $signed({sign, mag});
    endfunction

    // The tick restarts the accumulator, so a packet finishing on the tick edge
    // becomes the whole new accumulator rather than being lost.
    function automatic logic signed [11:0] acc_next(input logic signed [11:0] acc,
                                                    input logic tick, input logic done,
                                                    input logic signed [8:0] d);
        logic signed [12:0] s;
        s = (tick ? 13'sd0 : $signed({acc[11], acc}))
          + (done ? $signed({{4{d[8]}}, d}) : 13'sd0);
        if (s > 13'sd2047) begin
            return 12'sh7FF;
        end
        if (s < -13'sd2048) begin
            return 12'sh800;
        end
        return s[11:0];
    endfunction

    function automatic logic [9:0] clamp_pos(input logic signed [12:0] s,
                                             input logic [9:0] max_v);
        if (s < 13'sd0) begin
            return '0;
        end
        if (s > $signed({3'b000, max_v})) begin
            return max_v;
        end
        return s[9:0];
    endfunction

    // The third byte is used straight off the bus so buttons and accumulators
    // take the packet on the same edge that consumes it.
    assign w_pkt_done = (r_state == StGot1) && bus.rx_done;
    assign w_dx       = form_delta(r_x_sign, r_x_ovf, r_dx);
    assign w_dy       = form_delta(r_y_sign, r_y_ovf, bus.rx_data);

    // Edge-detect so a multi-clock pixel yields exactly one tick per frame.
    assign w_cond = (bus.ContV == 10'(V_APPLY)) && (bus.ContH == 10'd0);
    assign w_tick = w_cond & ~r_cond;

    // PS/2 +Y is up while screen Y grows downward, hence the subtraction.
    assign w_sum_h = $signed({3'b000, r_pos_h}) + $signed({r_acc_x[11], r_acc_x});
    assign w_sum_v = $signed({3'b000, r_pos_v}) - $signed({r_acc_y[11], r_acc_y});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_tmo     <= '0;
            r_hdr_btn <= '0;
            r_x_sign  <= 1'b0;
            r_y_sign  <= 1'b0;
            r_x_ovf   <= 1'b0;
            r_y_ovf   <= 1'b0;
            r_dx      <= '0;
            r_acc_x   <= '0;
            r_acc_y   <= '0;
            r_pos_h   <= 10'(H_INIT);
            r_pos_v   <= 10'(V_INIT);
            r_btn_l   <= 1'b0;
            r_btn_r   <= 1'b0;
            r_btn_m   <= 1'b0;
            r_upd     <= 1'b0;
            r_pkt_err <= 1'b0;
            r_cond    <= 1'b0;
        end else begin
            r_cond    <= w_cond;
            r_upd     <= w_tick;
            r_pkt_err <= 1'b0;

            r_acc_x <= acc_next(r_acc_x, w_tick, w_pkt_done, w_dx);
            r_acc_y <= acc_next(r_acc_y, w_tick, w_pkt_done, w_dy);

            if (w_tick) begin
                r_pos_h <= clamp_pos(w_sum_h, 10'(H_MAX));
                r_pos_v <= clamp_pos(w_sum_v, 10'(V_MAX));
            end

            if (w_pkt_done) begin
                r_btn_l <= r_hdr_btn[0];
                r_btn_r <= r_hdr_btn[1];
                r_btn_m <= r_hdr_btn[2];
            end

            case (r_state)
                StIdle: begin
                    r_tmo <= '0;
                    if (bus.rx_done) begin
                        // Bit 3 is always set in a header byte; anything else
                        // means we are out of step with the packet stream.
                        if (bus.rx_data[3]) begin
                            r_hdr_btn <= bus.rx_data[2:0];
                            r_x_sign  <= bus.rx_data[4];
                            r_y_sign  <= bus.rx_data[5];
                            r_x_ovf   <= bus.rx_data[6];
                            r_y_ovf   <= bus.rx_data[7];
                            r_state   <= StGot0;
                        end else begin
                            r_pkt_err <= 1'b1;
                        end
                    end
                end
                StGot0, StGot1: begin
                    if (bus.rx_done) begin
                        r_tmo <= '0;
                        if (r_state == StGot0) begin
                            r_dx    <= bus.rx_data;
                            r_state <= StGot1;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                        r_tmo     <= '0;
                        r_pkt_err <= 1'b1;
                        r_state   <= StIdle;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    r_tmo   <= '0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.PosH    = r_pos_h;
    assign bus.PosV    = r_pos_v;
    assign bus.BtnL    = r_btn_l;
    assign bus.BtnR    = r_btn_r;
    assign bus.BtnM    = r_btn_m;
    assign bus.upd     = r_upd;
    assign bus.pkt_err = r_pkt_err;

endmodule

// File: tb/tb_mouse_pos_ctrl.sv
// tb_mouse_pos_ctrl
// Table-driven packet vectors plus hand-written sequences for sync error,
// timeout, tick/packet collision, reset mid-packet and accumulator saturation.
// Expected positions are queued when a frame tick is driven and compared when
// the DUT pulses upd.
module tb_mouse_pos_ctrl;

    localparam int unsigned TMO = 64;

    logic clk;
    logic reset;

    mouse_pos_ctrl_if bus();

    mouse_pos_ctrl #(
        .H_MAX   (628),
        .V_MAX   (468),
        .H_INIT  (320),
        .V_INIT  (240),
        .V_APPLY (480),
        .TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic       tick;
        int         exp_h;
        int         exp_v;
        logic [2:0] exp_btn;    // {M, R, L}
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every upd must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.upd) begin
            chk("upd_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("posh_after_tick", int'(bus.PosH), int'(e.h));
                chk("posv_after_tick", int'(bus.PosV), int'(e.v));
            end
        end
    end

    task automatic add(input logic rst, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic tick, input int h, input int v,
                       input logic [2:0] btn);
        vec_t r;
        r.rst = rst; r.b0 = b0; r.b1 = b1; r.b2 = b2; r.tick = tick;
        r.exp_h = h; r.exp_v = v; r.exp_btn = btn;
        vecs.push_back(r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        bus.ContV = 10'd0;
        bus.ContH = 10'd5;
        @(negedge clk);
        @(negedge clk);
        sb.delete();
        chk("reset_posh", int'(bus.PosH), 320);
        chk("reset_posv", int'(bus.PosV), 240);
        chk("reset_btn", int'({bus.BtnM, bus.BtnR, bus.BtnL}), 0);
        chk("reset_upd_err", int'({bus.upd, bus.pkt_err}), 0);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic err);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_done = 1'b1;
        @(negedge clk);
        bus.rx_done = 1'b0;
        err = bus.pkt_err;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            output logic err);
        logic e0, e1, e2;
        send_byte(b0, e0);
        send_byte(b1, e1);
        send_byte(b2, e2);
        err = e0 | e1 | e2;
    endtask

    // Hold the blanking-line condition for several clocks: only one update may result.
    task automatic run_tick(input int h, input int v);
        exp_t e;
        e.h = 10'(h);
        e.v = 10'(v);
        sb.push_back(e);
        @(negedge clk);
        bus.ContV = 10'd480;
        bus.ContH = 10'd0;
        repeat (2) @(negedge clk);
        bus.ContV = 10'd0;
        bus.ContH = 10'd5;
        @(negedge clk);
        chk("upd_pending", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic err;
        int   cyc;

        reset = 1'b1;
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b0;
        bus.ContV = 10'd0;
        bus.ContH = 10'd5;

        add(1, 8'h08, 8'h0A, 8'h05, 1, 330, 235, 3'b000);
        add(1, 8'h19, 8'hF6, 8'h00, 1, 310, 240, 3'b001);
        for (int i = 0; i < 7; i++) add(i == 0, 8'h08, 8'h7F, 8'h00, 0, 320, 240, 3'b000);
        add(0, 8'h08, 8'h7F, 8'h00, 1, 628, 240, 3'b000);
        add(0, 8'h18, 8'h00, 8'h00, 1, 372, 240, 3'b000);
        add(0, 8'h58, 8'h00, 8'h00, 1, 116, 240, 3'b000);
        add(0, 8'h08, 8'h00, 8'h7F, 0, 116, 240, 3'b000);
        add(0, 8'h08, 8'h00, 8'h7F, 0, 116, 240, 3'b000);
        add(0, 8'h08, 8'h00, 8'h7F, 1, 116, 0, 3'b000);
        for (int i = 0; i < 3; i++) add(0, 8'h38, 8'h00, 8'h81, 0, 116, 0, 3'b000);
        add(0, 8'h3F, 8'h00, 8'h81, 1, 0, 468, 3'b111);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2, err);
            chk("vec_pkt_err", int'(err), 0);
            chk("vec_btn", int'({bus.BtnM, bus.BtnR, bus.BtnL}), int'(vecs[i].exp_btn));
            if (vecs[i].tick) begin
                run_tick(vecs[i].exp_h, vecs[i].exp_v);
            end else begin
                chk("vec_posh_hold", int'(bus.PosH), vecs[i].exp_h);
                chk("vec_posv_hold", int'(bus.PosV), vecs[i].exp_v);
            end
        end

        // Sync error: non-header byte in IDLE is dropped with a one-cycle pkt_err.
        do_reset();
        send_byte(8'h00, err);
        chk("sync_err_pulse", int'(err), 1);
        @(negedge clk);
        chk("sync_err_one_cycle", int'(bus.pkt_err), 0);
        send_pkt(8'h08, 8'h01, 8'h01, err);
        chk("sync_next_pkt_err", int'(err), 0);
        run_tick(321, 239);

        // Timeout after two bytes: partial packet discarded.
        send_byte(8'h08, err);
        send_byte(8'h05, err);
        cyc = 0;
        for (int i = 1; i <= 4 * TMO; i++) begin
            @(negedge clk);
            if (bus.pkt_err) begin
                cyc = i;
                break;
            end
        end
        chk("timeout_seen", int'(cyc != 0), 1);
        chk("timeout_window", int'(cyc >= TMO - 1 && cyc <= TMO + 1), 1);
        run_tick(321, 239);
        send_pkt(8'h08, 8'h01, 8'h01, err);
        chk("post_timeout_err", int'(err), 0);
        run_tick(322, 238);

        // Collision: third byte lands on the tick edge.
        do_reset();
        send_pkt(8'h08, 8'h04, 8'h00, err);
        send_byte(8'h08, err);
        send_byte(8'h03, err);
        begin
            exp_t e;
            e.h = 10'd324;
            e.v = 10'd240;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.rx_data = 8'h00;
        bus.rx_done = 1'b1;
        bus.ContV = 10'd480;
        bus.ContH = 10'd0;
        @(negedge clk);
        bus.rx_done = 1'b0;
        @(negedge clk);
        bus.ContV = 10'd0;
        bus.ContH = 10'd5;
        @(negedge clk);
        chk("collision_upd_pending", sb.size(), 0);
        sb.delete();
        run_tick(327, 240);

        // Reset mid-packet drops both the pending accumulation and the partial packet.
        send_pkt(8'h08, 8'h10, 8'h00, err);
        send_byte(8'h08, err);
        send_byte(8'h05, err);
        do_reset();
        send_pkt(8'h08, 8'h02, 8'h00, err);
        chk("post_reset_err", int'(err), 0);
        run_tick(322, 240);

        // Accumulator saturates at -2048 instead of wrapping.
        do_reset();
        for (int i = 0; i < 17; i++) send_pkt(8'h18, 8'h00, 8'h00, err);
        chk("sat_posh_hold", int'(bus.PosH), 320);
        run_tick(0, 240);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
